// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_param
// Purpose  : Serial sequence detector. A start pulse captures a switch word
//            and a target pattern. The word is then shifted out LSB-first at
//            one bit per TICK_DIV clocks, and every occurrence of the pattern
//            is counted, in overlapping or non-overlapping mode.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detect_param #(
  parameter int DATA_W   = 8,
  parameter int PAT_W    = 5,
  parameter int TICK_DIV = 50_000_000,
  parameter int OVERLAP  = 1,
  parameter int CNT_W    = $clog2(DATA_W - PAT_W + 2)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [DATA_W-1:0]           data_in,
  input  logic [PAT_W-1:0]            pattern,
  output logic                        busy,
  output logic                        done,
  output logic                        match,
  output logic [CNT_W-1:0]            match_cnt,
  output logic                        led,
  output logic [$clog2(DATA_W)-1:0]   bit_idx
);

  localparam int c_idx_w  = $clog2(DATA_W);
  localparam int c_tick_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_fill_w = $clog2(PAT_W + 1);

  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DIV - 1);
  localparam logic [c_idx_w-1:0]  c_idx_last  = c_idx_w'(DATA_W - 1);
  localparam logic [c_fill_w-1:0] c_fill_max  = c_fill_w'(PAT_W);
  localparam logic [c_fill_w-1:0] c_fill_need = c_fill_w'(PAT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [DATA_W-1:0]    r_data;
  logic [PAT_W-1:0]     r_pat;
  logic [PAT_W-2:0]     r_hist;      // the PAT_W-1 most recent bits, newest in bit 0
  logic [c_fill_w-1:0]  r_fill;      // valid bits in r_hist, saturates at PAT_W
  logic [c_idx_w-1:0]   r_bit_idx;
  logic [c_tick_w-1:0]  r_tick;
  logic [CNT_W-1:0]     r_match_cnt;
  logic                 r_match;
  logic                 r_led;

  logic                 w_consume;
  logic                 w_bit;
  logic [PAT_W-1:0]     w_window;
  logic                 w_hit;
  logic                 w_last;

  // Bit consumption strobe and match decode for the bit being consumed
  always_comb begin
    w_consume = (r_state == S_SHIFT) && (r_tick == c_tick_last);
    w_bit     = r_data[r_bit_idx];
    w_window  = {r_hist, w_bit};
    w_hit     = w_consume && (r_fill >= c_fill_need) && (w_window == r_pat);
    w_last    = (r_bit_idx == c_idx_last);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; start restarts the run from any state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (start)                  w_state_next = S_SHIFT;
        else if (w_consume && w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        w_state_next = start ? S_SHIFT : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: capture on start, otherwise tick and consume bits while shifting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data      <= '0;
      r_pat       <= '0;
      r_hist      <= '0;
      r_fill      <= '0;
      r_bit_idx   <= '0;
      r_tick      <= '0;
      r_match_cnt <= '0;
      r_match     <= 1'b0;
      r_led       <= 1'b0;
    end else begin
      r_match <= 1'b0;
      if (start) begin
        // A start coincident with a consumption edge discards that bit.
        r_data      <= data_in;
        r_pat       <= pattern;
        r_hist      <= '0;
        r_fill      <= '0;
        r_bit_idx   <= '0;
        r_tick      <= '0;
        r_match_cnt <= '0;
        r_led       <= 1'b0;
      end else if (r_state == S_SHIFT) begin
        if (w_consume) begin
          r_tick    <= '0;
          r_bit_idx <= r_bit_idx + c_idx_w'(1);
          if (w_hit) begin
            r_match     <= 1'b1;
            r_match_cnt <= r_match_cnt + CNT_W'(1);
            r_led       <= 1'b1;
          end
          if (w_hit && (OVERLAP == 0)) begin
            // Non-overlapping: a match consumes its bits, history restarts.
            r_hist <= '0;
            r_fill <= '0;
          end else begin
            r_hist <= w_window[PAT_W-2:0];
            r_fill <= (r_fill == c_fill_max) ? r_fill : r_fill + c_fill_w'(1);
          end
        end else begin
          r_tick <= r_tick + c_tick_w'(1);
        end
      end
    end
  end

  assign busy      = (r_state == S_SHIFT);
  assign done      = (r_state == S_DONE);
  assign match     = r_match;
  assign match_cnt = r_match_cnt;
  assign led       = r_led;
  assign bit_idx   = r_bit_idx;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detect_param
// Purpose  : Scoreboard bench for seq_detect_param. Three configurations are
//            driven from one stimulus stream; a per-configuration predictor
//            queues the expected pulses and a monitor checks them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detect_param;

  localparam int DW = 8;
  localparam int PW = 5;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] data_in;
  logic [PW-1:0] pattern;

  longint cyc = 0;
  int     n_chk = 0;
  int     n_ok  = 0;

  typedef struct {
    longint t;
    bit     m;
    bit     d;
    int     cnt;
    bit     led;
    int     idx;
  } ev_t;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after edge n, cyc == n
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    n_chk++;
    if (ok) n_ok++;
    else $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
  endtask

  // Reference: which bit positions complete a detection, from the matching rules
  function automatic logic [DW-1:0] ref_hits(input logic [DW-1:0] d, input logic [PW-1:0] p,
                                             input int ovl);
    logic [DW-1:0] h;
    int            last;
    bit            ok;
    h    = '0;
    last = -100;
    for (int k = PW - 1; k < DW; k++) begin
      ok = 1'b1;
      for (int j = 0; j < PW; j++)
        if (d[k-PW+1+j] != p[PW-1-j]) ok = 1'b0;
      if (ok && (ovl != 0 || (k - last) >= PW)) begin
        h[k] = 1'b1;
        last = k;
      end
    end
    return h;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int TD = (gi == 0) ? 4 : (gi == 1) ? 1 : 3;
    localparam int OV = (gi == 2) ? 0 : 1;

    logic       busy_o, done_o, match_o, led_o;
    logic [2:0] cnt_o;
    logic [2:0] idx_o;

    ev_t    q[$];
    ev_t    e;
    longint b_lo = 1;
    longint b_hi = 0;
    longint e0;
    int     cnt;
    logic [DW-1:0] h;
    logic [19:0]   act, exp;
    bit            exp_busy;

    seq_detect_param #(
      .DATA_W(DW), .PAT_W(PW), .TICK_DIV(TD), .OVERLAP(OV)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in), .pattern(pattern),
      .busy(busy_o), .done(done_o), .match(match_o), .match_cnt(cnt_o),
      .led(led_o), .bit_idx(idx_o)
    );

    // Predictor: on an accepted start, drop the aborted run's future events and queue the new run
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q.delete();
        b_lo = 1;
        b_hi = 0;
      end else if (start) begin
        e0 = cyc + 1;
        while (q.size() > 0 && q[q.size()-1].t >= e0) void'(q.pop_back());
        h = ref_hits(data_in, pattern, OV);
        e.t = e0; e.m = 0; e.d = 0; e.cnt = 0; e.led = 0; e.idx = 0;
        q.push_back(e);
        cnt = 0;
        for (int k = 0; k < DW; k++) begin
          if (h[k] || k == DW - 1) begin
            if (h[k]) cnt++;
            e.t   = e0 + longint'((k + 1) * TD);
            e.m   = h[k];
            e.d   = (k == DW - 1);
            e.cnt = cnt;
            e.led = (cnt > 0);
            e.idx = (k + 1) % DW;
            q.push_back(e);
          end
        end
        b_lo = e0;
        b_hi = e0 + longint'(DW * TD) - 1;
      end
    end

    // Monitor: compare busy every cycle and pulses/counters against the queue
    always @(negedge clk) begin
      if (!rst_n) begin
        act = {match_o, done_o, led_o, busy_o, 8'(cnt_o), 8'(idx_o)};
        chk(act == 20'h0, $sformatf("reset_state[cfg%0d]", gi), act, 0);
      end else begin
        exp_busy = (cyc >= b_lo) && (cyc <= b_hi);
        chk(busy_o == exp_busy, $sformatf("busy[cfg%0d]", gi), busy_o, exp_busy);
        while (q.size() > 0 && q[0].t < cyc) begin
          chk(1'b0, $sformatf("missing_event[cfg%0d]", gi), 0, q[0].t);
          void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].t == cyc) begin
          e   = q.pop_front();
          act = {match_o, done_o, led_o, 1'b0, 8'(cnt_o), 8'(idx_o)};
          exp = {e.m, e.d, e.led, 1'b0, 8'(e.cnt), 8'(e.idx)};
          chk(act == exp, $sformatf("event[cfg%0d]", gi), act, exp);
        end else if (match_o || done_o) begin
          chk(1'b0, $sformatf("unexpected_pulse[cfg%0d]", gi), {match_o, done_o}, 0);
        end
      end
    end
  end

  // Present a start; the next start is sampled gap edges after this one
  task automatic run(input logic [DW-1:0] d, input logic [PW-1:0] p, input int gap);
    start   = 1'b1;
    data_in = d;
    pattern = p;
    @(posedge clk);
    #2;
    start   = 1'b0;
    data_in = DW'($urandom);
    pattern = PW'($urandom);
    repeat (gap - 1) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  logic [DW-1:0] d;
  logic [PW-1:0] p;
  int            o;

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    data_in = '0;
    pattern = '0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    run(8'hDA, 5'b01011, 40);   // single match after bit 4
    run(8'h2A, 5'b01010, 40);   // overlap vs non-overlap
    run(8'hFF, 5'b01011, 40);   // no match
    run(8'hFF, 5'b11111, 40);   // back-to-back matches at one bit per clock
    run(8'h00, 5'b00000, 40);   // all-zero pattern needs a full history
    run(8'hA5, 5'b01011, 10);   // aborted by the next start
    run(8'hDA, 5'b01011, 33);   // next start lands in the DONE cycle of cfg0
    run(8'hDA, 5'b01011, 15);   // reset mid-run
    do_reset();
    run(8'hDA, 5'b01011, 40);

    for (int i = 0; i < 60; i++) begin
      d = DW'($urandom);
      if ($urandom_range(0, 2) != 0) begin
        o = $urandom_range(0, DW - PW);
        for (int j = 0; j < PW; j++) p[PW-1-j] = d[o+j];
      end else begin
        p = PW'($urandom);
      end
      run(d, p, $urandom_range(1, 40));
      if ($urandom_range(0, 9) == 0) do_reset();
    end

    repeat (60) @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
